button_event_decoder: RTL and testbench
=======================================

Name: button_event_decoder

Overview:
- Consumes the clean, debounced switch level produced by the switch debouncer and turns it into single-cycle user-interface events: press, release, short press, long press and double click.
- Also drives a long-hold level for auto-repeat logic.
- Sits between the debouncer output and the control FSMs / LED logic that react to buttons.

Parameters:
CNT_W, 24, width of the internal hold/gap counter.
LONG_CYCLES, 12000000, press length in clock cycles that qualifies as a long press (1 ≤ value ≤ 2^CNT_W−1).
DBL_GAP, 5000000, maximum release-to-press gap in cycles for a double click (1 ≤ value ≤ 2^CNT_W−1).
ACTIVE_HIGH, 1, 1: switchIn=1 means pressed; 0: switchIn=0 means pressed.

Ports:
clk  input  1  system clock; all state on rising edge.
rstN  input  1  asynchronous, active-low reset.
switchIn  input  1  debounced switch level, synchronous to clk.
pressPulse  output  1  one-cycle pulse on press.
releasePulse  output  1  one-cycle pulse on release.
shortPress  output  1  one-cycle pulse: a single press shorter than LONG_CYCLES, not followed by a second press within DBL_GAP.
longPress  output  1  one-cycle pulse when a press reaches LONG_CYCLES.
doubleClick  output  1  one-cycle pulse on the second press of a double click.
longHold  output  1  level: high while a long press is still held.

Behaviour:
- Reset is asynchronous and active-low. While rstN=0, all outputs are 0, state=IDLE, cnt=0, and btnQ=released.
- A button held through reset gives a pressPulse at the first edge after rstN deasserts.
- btn = switchIn XNOR ACTIVE_HIGH. btnQ is btn registered every edge.
- Edge detection: rise = btn & ~btnQ, fall = ~btn & btnQ, both evaluated before the edge.
- All outputs are registered. An event sampled at edge k is visible in the cycle after edge k (1-edge latency).
- Pulse outputs default to 0 every edge, so they are never wider than one cycle.
- States: IDLE, PRESSED1, LONG_HELD, WAIT_SECOND, PRESSED2.
  - IDLE: on rise, set pressPulse, cnt←0, go to PRESSED1.
  - PRESSED1: on fall, set releasePulse, cnt←0, go to WAIT_SECOND. Otherwise, if cnt==LONG_CYCLES−1, set longPress and go to LONG_HELD; else cnt←cnt+1. The longPress edge is k+LONG_CYCLES, where k is the rise edge.
  - LONG_HELD: longHold=1. On fall, set releasePulse and go to IDLE. No shortPress is issued.
  - WAIT_SECOND: on rise, set pressPulse and doubleClick, go to PRESSED2. Otherwise, if cnt==DBL_GAP−1, set shortPress and go to IDLE; else cnt←cnt+1. shortPress lands at edge r+DBL_GAP, where r is the release edge.
  - PRESSED2: on fall, set releasePulse and go to IDLE. There is no long detection on the second press, and cnt holds.
- Simultaneous events:
  - In WAIT_SECOND, rise at the timeout edge wins: doubleClick is issued, shortPress is not.
  - In PRESSED1, fall at the long-threshold edge wins: release path, no longPress.
- Counter: unsigned CNT_W bits. It never wraps because it is bounded by the compare-and-leave logic.
- A triple click decodes as doubleClick followed by a fresh sequence starting from IDLE.
- Reset mid-sequence aborts without emitting any event.

Test Plan (all scenarios use CNT_W=4, LONG_CYCLES=8, DBL_GAP=5, ACTIVE_HIGH=1):
- Reset: hold rstN=0 and toggle switchIn → all outputs 0. Release reset with switchIn=0 → no pulses for 20 cycles.
- Short press: switchIn 0→1 sampled at edge 10, 1→0 sampled at edge 13 → pressPulse after edge 10, releasePulse after edge 13, shortPress after edge 18, no other pulses.
- Long press: switchIn high from edge 10 to edge 25 → pressPulse after edge 10, longPress after edge 18, longHold high edges 18–25, releasePulse after edge 25, no shortPress.
- Double click: press at edges 10–11, release at edge 12, press at edge 15, release at edge 17 → pressPulse after edges 10 and 15, doubleClick after edge 15, releasePulse after edges 12 and 17, no shortPress, state IDLE after edge 17.
- Boundaries:
  - Release at edge 12, second press sampled exactly at edge 17 → doubleClick, no shortPress.
  - Press at edge 10 with fall sampled at edge 18 → releasePulse, no longPress, shortPress after edge 23.
- Async reset mid-hold: pulse rstN low between edges 14 and 15 during a long press → outputs clear immediately. If switchIn is still high, pressPulse appears after the first edge following deassertion and longPress comes LONG_CYCLES edges later.

Source files
------------

// File: rtl/button_event_decoder.sv
// Turns a debounced switch level into press/release/short/long/double-click pulses plus a long-hold level.
// One-edge latency on every output; no backpressure, events are fire-and-forget single-cycle pulses.
module button_event_decoder #(
    parameter int unsigned CNT_W       = 24,
    parameter int unsigned LONG_CYCLES = 12000000,
    parameter int unsigned DBL_GAP     = 5000000,
    parameter bit          ACTIVE_HIGH = 1'b1
) (
    input  logic clk,
    input  logic rstN,
    input  logic switchIn,
    output logic pressPulse,
    output logic releasePulse,
    output logic shortPress,
    output logic longPress,
    output logic doubleClick,
    output logic longHold
);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        PRESSED1    = 3'd1,
        LONG_HELD   = 3'd2,
        WAIT_SECOND = 3'd3,
        PRESSED2    = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(DBL_GAP - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_btn_q;
    logic             w_btn;
    logic             w_rise;
    logic             w_fall;

    logic r_press, r_release, r_short, r_long, r_dbl, r_hold;
    logic w_press, w_release, w_short, w_long, w_dbl;

    assign w_btn  = switchIn ~^ ACTIVE_HIGH;
    assign w_rise = w_btn & ~r_btn_q;
    assign w_fall = ~w_btn & r_btn_q;

    // Edge events take priority over counter timeouts on the same edge.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_press     = 1'b0;
        w_release   = 1'b0;
        w_short     = 1'b0;
        w_long      = 1'b0;
        w_dbl       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_rise) begin
                    w_press     = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = PRESSED1;
                end
            end
            PRESSED1: begin
                if (w_fall) begin
                    w_release   = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = WAIT_SECOND;
                end else if (r_cnt == LONG_LAST) begin
                    w_long      = 1'b1;
                    w_state_nxt = LONG_HELD;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_ONE;
                end
            end
            LONG_HELD: begin
                if (w_fall) begin
                    w_release   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            WAIT_SECOND: begin
                if (w_rise) begin
                    w_press     = 1'b1;
                    w_dbl       = 1'b1;
                    w_state_nxt = PRESSED2;
                end else if (r_cnt == GAP_LAST) begin
                    w_short     = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_ONE;
                end
            end
            PRESSED2: begin
                if (w_fall) begin
                    w_release   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_btn_q   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_short   <= 1'b0;
            r_long    <= 1'b0;
            r_dbl     <= 1'b0;
            r_hold    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_btn_q   <= w_btn;
            r_press   <= w_press;
            r_release <= w_release;
            r_short   <= w_short;
            r_long    <= w_long;
            r_dbl     <= w_dbl;
            r_hold    <= (w_state_nxt == LONG_HELD);
        end
    end

    assign pressPulse   = r_press;
    assign releasePulse = r_release;
    assign shortPress   = r_short;
    assign longPress    = r_long;
    assign doubleClick  = r_dbl;
    assign longHold     = r_hold;

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder with CNT_W=4, LONG_CYCLES=8, DBL_GAP=5.
module tb_button_event_decoder;

    logic clk;
    logic rstN;
    logic switchIn;
    logic pressPulse, releasePulse, shortPress, longPress, doubleClick, longHold;

    int checks = 0;
    int errors = 0;

    // Output vector order: {press, release, short, long, double, hold}
    localparam logic [5:0] Z = 6'b000000;
    localparam logic [5:0] P = 6'b100000;
    localparam logic [5:0] R = 6'b010000;
    localparam logic [5:0] S = 6'b001000;
    localparam logic [5:0] L = 6'b000100;
    localparam logic [5:0] D = 6'b000010;
    localparam logic [5:0] H = 6'b000001;

    button_event_decoder #(
        .CNT_W       (4),
        .LONG_CYCLES (8),
        .DBL_GAP     (5),
        .ACTIVE_HIGH (1'b1)
    ) dut (
        .clk          (clk),
        .rstN         (rstN),
        .switchIn     (switchIn),
        .pressPulse   (pressPulse),
        .releasePulse (releasePulse),
        .shortPress   (shortPress),
        .longPress    (longPress),
        .doubleClick  (doubleClick),
        .longHold     (longHold)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [5:0] outs();
        return {pressPulse, releasePulse, shortPress, longPress, doubleClick, longHold};
    endfunction

    task automatic check(input string tag, input logic [5:0] exp);
        logic [5:0] obs;
        obs = outs();
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic [5:0] exp, input string tag);
        @(posedge clk);
        #1;
        check(tag, exp);
    endtask

    task automatic ticks(input int n, input logic [5:0] exp, input string tag);
        for (int i = 0; i < n; i++) tick(exp, tag);
    endtask

    initial begin
        rstN     = 1'b0;
        switchIn = 1'b0;

        // Reset held while the switch toggles
        #3;
        check("rst_init", Z);
        for (int i = 0; i < 4; i++) begin
            switchIn = ~switchIn;
            tick(Z, "rst_toggle");
        end
        switchIn = 1'b0;
        tick(Z, "rst_last");
        rstN = 1'b1;
        ticks(20, Z, "post_rst_quiet");

        // Short press: press sampled at A, release at A+3, short at A+8
        switchIn = 1'b1;
        tick(P, "short_press");
        ticks(2, Z, "short_held");
        switchIn = 1'b0;
        tick(R, "short_release");
        ticks(4, Z, "short_gap");
        tick(S, "short_fire");
        ticks(3, Z, "short_after");

        // Long press: rise at k, long at k+8, release at k+15
        switchIn = 1'b1;
        tick(P, "long_press");
        ticks(7, Z, "long_count");
        tick(L | H, "long_fire");
        ticks(6, H, "long_hold");
        switchIn = 1'b0;
        tick(R, "long_release");
        ticks(8, Z, "long_no_short");

        // Double click: press 10-11, release 12, press 15, release 17
        switchIn = 1'b1;
        tick(P, "dbl_p1");
        tick(Z, "dbl_h1");
        switchIn = 1'b0;
        tick(R, "dbl_r1");
        ticks(2, Z, "dbl_gap");
        switchIn = 1'b1;
        tick(P | D, "dbl_p2");
        tick(Z, "dbl_h2");
        switchIn = 1'b0;
        tick(R, "dbl_r2");
        ticks(2, Z, "dbl_idle");
        // Third click starts fresh from IDLE: plain press, then short
        switchIn = 1'b1;
        tick(P, "trip_press");
        switchIn = 1'b0;
        tick(R, "trip_release");
        ticks(4, Z, "trip_gap");
        tick(S, "trip_short");
        ticks(3, Z, "trip_after");

        // Second press exactly at the gap timeout edge wins
        switchIn = 1'b1;
        tick(P, "bnd_gap_p1");
        tick(Z, "bnd_gap_h1");
        switchIn = 1'b0;
        tick(R, "bnd_gap_r1");
        ticks(4, Z, "bnd_gap_wait");
        switchIn = 1'b1;
        tick(P | D, "bnd_gap_dbl");
        switchIn = 1'b0;
        tick(R, "bnd_gap_r2");
        ticks(8, Z, "bnd_gap_no_short");

        // Release exactly at the long threshold edge wins
        switchIn = 1'b1;
        tick(P, "bnd_long_press");
        ticks(7, Z, "bnd_long_count");
        switchIn = 1'b0;
        tick(R, "bnd_long_release");
        ticks(4, Z, "bnd_long_gap");
        tick(S, "bnd_long_short");
        ticks(3, Z, "bnd_long_after");

        // Async reset mid-hold, switch kept high across reset
        switchIn = 1'b1;
        tick(P, "arst_press");
        ticks(4, Z, "arst_count");
        #2 rstN = 1'b0;
        #1 check("arst_clear", Z);
        tick(Z, "arst_in_reset");
        rstN = 1'b1;
        tick(P, "arst_repress");
        ticks(7, Z, "arst_count2");
        tick(L | H, "arst_long");
        ticks(2, H, "arst_hold");
        #2 rstN = 1'b0;
        #1 check("arst_hold_clear", Z);
        switchIn = 1'b0;
        tick(Z, "arst_in_reset2");
        rstN = 1'b1;
        ticks(8, Z, "arst_quiet");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
